rotate_issue_stage: RTL and testbench

ROTATE_ISSUE_STAGE -- requirements
Module: rotate_issue_stage

---
 rtl/rotate_issue_stage_pkg.sv | 26 ++
 rtl/rotate_issue_stage_if.sv | 30 +++
 rtl/rot_cmd_fifo.sv | 59 +++++
 rtl/rotate_issue_stage.sv | 80 ++++++++
 tb/tb_rotate_issue_stage.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rotate_issue_stage_pkg.sv
// Shared widths, queued-command record and amount normalisation for the rotate issue stage.
package rotate_issue_stage_pkg;

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned AMT_W   = 4;
  localparam int unsigned SHIFT_W = 3;

  typedef struct packed {
    logic [CMD_W-1:0]   data;
    logic [SHIFT_W-1:0] shift;
    logic               dir;    // 1 = left, 0 = right
  } rot_cmd_t;

  // -8 negates to 8, whose low bits are zero: a right rotate by 0 (pass-through).
  function automatic rot_cmd_t normalize_cmd(input logic [CMD_W-1:0] data,
                                             input logic [AMT_W-1:0] amt);
    rot_cmd_t         cmd;
    logic [AMT_W-1:0] mag;
    mag       = amt[AMT_W-1] ? -amt : amt;
    cmd.data  = data;
    cmd.shift = mag[SHIFT_W-1:0];
    cmd.dir   = ~amt[AMT_W-1];
    return cmd;
  endfunction

endpackage

// File: rtl/rotate_issue_stage_if.sv
// Command, shifter and result handshake bundle of the rotate issue stage.
interface rotate_issue_stage_if
  import rotate_issue_stage_pkg::*;
();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [CMD_W-1:0]   cmd_data;
  logic [AMT_W-1:0]   cmd_amt;

  logic [CMD_W-1:0]   sh_in;
  logic [SHIFT_W-1:0] sh_shift;
  logic               sh_dir;
  logic [CMD_W-1:0]   sh_out;

  logic               res_valid;
  logic               res_ready;
  logic [CMD_W-1:0]   res_data;

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, sh_out, res_ready,
    output cmd_ready, sh_in, sh_shift, sh_dir, res_valid, res_data
  );

  modport master (
    output cmd_valid, cmd_data, cmd_amt, sh_out, res_ready,
    input  cmd_ready, sh_in, sh_shift, sh_dir, res_valid, res_data
  );

endinterface

// File: rtl/rot_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO of normalised rotate commands with full/empty flags.
module rot_cmd_fifo
  import rotate_issue_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  rot_cmd_t wdata,
  input  logic     pop,
  output rot_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  rot_cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rotate_issue_stage.sv
// Rotate issue stage: normalises and queues commands, feeds an external barrel shifter from
// the queue head and registers its result behind a valid/ready output.
module rotate_issue_stage
  import rotate_issue_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2  // power of two, >= 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rotate_issue_stage_if.slave  bus,
  output logic [7:0]           op_count,
  output logic                 busy
);

  rot_cmd_t         head;
  logic             full, empty;
  logic             push, pop;
  logic             res_valid_q, res_valid_d;
  logic [CMD_W-1:0] res_data_q, res_data_d;
  logic [7:0]       op_count_q, op_count_d;

  // Ready depends only on registered occupancy, never on the downstream side.
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = !empty && (!res_valid_q || bus.res_ready);

  rot_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (normalize_cmd(bus.cmd_data, bus.cmd_amt)),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.sh_in    = '0;
    bus.sh_shift = '0;
    bus.sh_dir   = 1'b0;
    if (!empty) begin
      bus.sh_in    = head.data;
      bus.sh_shift = head.shift;
      bus.sh_dir   = head.dir;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.sh_out;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
    op_count_d = op_count_q + 8'(res_valid_q && bus.res_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign op_count      = op_count_q;
  assign busy          = !empty || res_valid_q;

endmodule

// File: tb/tb_rotate_issue_stage.sv
// Directed bench for rotate_issue_stage with a behavioural barrel shifter on the sh_* port.
module tb_rotate_issue_stage;
  import rotate_issue_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] op_count;
  logic       busy;
  int         checks   = 0;
  int         failures = 0;

  rotate_issue_stage_if bus ();

  rotate_issue_stage #(
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Rotate by shifting a doubled copy of the operand.
  logic [15:0] sh_tmp;
  always_comb begin
    sh_tmp = {bus.sh_in, bus.sh_in};
    if (bus.sh_dir) begin
      sh_tmp     = sh_tmp << bus.sh_shift;
      bus.sh_out = sh_tmp[15:8];
    end else begin
      sh_tmp     = sh_tmp >> bus.sh_shift;
      bus.sh_out = sh_tmp[7:0];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] a);
    bus.cmd_valid = v;
    bus.cmd_data  = d;
    bus.cmd_amt   = a;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // data, amount, expected dir, expected shift, expected rotated result
  logic [7:0] v_data  [6] = '{8'h81, 8'hB4, 8'h5A, 8'h01, 8'h03, 8'hC3};
  logic [3:0] v_amt   [6] = '{4'h1,  4'hD,  4'h8,  4'h7,  4'hF,  4'h0};
  logic       v_dir   [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
  logic [2:0] v_shift [6] = '{3'd1,  3'd3,  3'd0,  3'd7,  3'd1,  3'd0};
  logic [7:0] v_res   [6] = '{8'h03, 8'h96, 8'h5A, 8'h80, 8'h81, 8'hC3};

  initial begin
    int         seen, errs, notready, in_loop;
    logic [7:0] expb;

    drive(1'b0, 8'h00, 4'h0);
    bus.res_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_data", bus.res_data, 0);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sh_in", bus.sh_in, 0);
    check_eq("rst_sh_shift", bus.sh_shift, 0);
    check_eq("rst_sh_dir", bus.sh_dir, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_cmd_ready", bus.cmd_ready, 1);

    // Single commands: normalisation, latency and hand-off.
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, v_data[i], v_amt[i]);
      step();
      drive(1'b0, 8'h00, 4'h0);
      check_eq($sformatf("vec%0d_sh_in", i), bus.sh_in, v_data[i]);
      check_eq($sformatf("vec%0d_sh_dir", i), bus.sh_dir, v_dir[i]);
      check_eq($sformatf("vec%0d_sh_shift", i), bus.sh_shift, v_shift[i]);
      check_eq($sformatf("vec%0d_early_valid", i), bus.res_valid, 0);
      step();
      check_eq($sformatf("vec%0d_res_valid", i), bus.res_valid, 1);
      check_eq($sformatf("vec%0d_res_data", i), bus.res_data, v_res[i]);
      step();
      check_eq($sformatf("vec%0d_drained", i), bus.res_valid, 0);
    end
    check_eq("vec_op_count", op_count, 6);
    check_eq("vec_busy", busy, 0);

    // Backpressure: one held plus two queued fills the stage.
    bus.res_ready = 1'b0;
    drive(1'b1, 8'h11, 4'h1);
    check_eq("bp_ready_a", bus.cmd_ready, 1);
    step();
    drive(1'b1, 8'h80, 4'hF);
    check_eq("bp_ready_b", bus.cmd_ready, 1);
    step();
    drive(1'b1, 8'h0F, 4'h4);
    check_eq("bp_ready_c", bus.cmd_ready, 1);
    step();
    drive(1'b1, 8'h12, 4'h2);
    check_eq("bp_full_ready", bus.cmd_ready, 0);
    check_eq("bp_held_data", bus.res_data, 8'h22);
    check_eq("bp_held_valid", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    step();
    check_eq("bp_res_b", bus.res_data, 8'h40);
    check_eq("bp_ready_after_pop", bus.cmd_ready, 1);
    step();
    check_eq("bp_res_c", bus.res_data, 8'hF0);
    drive(1'b0, 8'h00, 4'h0);
    step();
    check_eq("bp_res_d", bus.res_data, 8'h48);
    check_eq("bp_res_d_valid", bus.res_valid, 1);
    step();
    check_eq("bp_drained", bus.res_valid, 0);
    check_eq("bp_busy", busy, 0);
    check_eq("bp_op_count", op_count, 10);

    // Streaming: 300 commands, one result per cycle, op_count wraps.
    apply_reset();
    bus.res_ready = 1'b1;
    seen = 0;
    errs = 0;
    notready = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'(i), 4'h1);
      if (!bus.cmd_ready) notready++;
      step();
      if (bus.res_valid) begin
        expb = 8'(seen);
        if (bus.res_data !== {expb[6:0], expb[7]}) errs++;
        seen++;
      end
    end
    in_loop = seen;
    drive(1'b0, 8'h00, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.res_valid) begin
        expb = 8'(seen);
        if (bus.res_data !== {expb[6:0], expb[7]}) errs++;
        seen++;
      end
    end
    check_eq("stream_in_loop", in_loop, 299);
    check_eq("stream_total", seen, 300);
    check_eq("stream_data_errs", errs, 0);
    check_eq("stream_notready", notready, 0);
    check_eq("stream_op_count", op_count, 44);
    check_eq("stream_busy", busy, 0);

    // Reset with one result held and two commands queued.
    bus.res_ready = 1'b0;
    drive(1'b1, 8'h11, 4'h1);
    step();
    drive(1'b1, 8'h80, 4'hF);
    step();
    drive(1'b1, 8'h0F, 4'h4);
    step();
    drive(1'b0, 8'h00, 4'h0);
    check_eq("mr_pre_full", bus.cmd_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_res_valid", bus.res_valid, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_res_data", bus.res_data, 0);
    check_eq("mr_op_count", op_count, 0);
    check_eq("mr_sh_in", bus.sh_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    drive(1'b1, 8'h44, 4'hE);
    check_eq("mr_ready", bus.cmd_ready, 1);
    step();
    drive(1'b0, 8'h00, 4'h0);
    check_eq("mr_no_stale", bus.res_valid, 0);
    check_eq("mr_sh_shift", bus.sh_shift, 2);
    step();
    check_eq("mr_new_valid", bus.res_valid, 1);
    check_eq("mr_new_data", bus.res_data, 8'h11);
    step();
    check_eq("mr_op_count_after", op_count, 1);
    check_eq("mr_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
